// File: rtl/inst_queue_pkg.sv
// Shared types and default sizing for the fetch-to-decode instruction queue.
package Public_Info;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } iq_entry_t;

  localparam int IQ_DEPTH = 16;
  localparam int FETCH_W  = 2;
  localparam int DECODE_W = 2;

endpackage

// File: rtl/inst_queue_lane_compact.sv
// Prefix popcount over the fetch valid mask: each lane gets its slot offset
// from tail, and the total tells how far tail advances.
module lane_compact #(
  parameter int IN_W = 2
) (
  input  logic [IN_W-1:0]                     i_valid,
  output logic [IN_W-1:0][$clog2(IN_W+1)-1:0] o_offset,
  output logic [$clog2(IN_W+1)-1:0]           o_n_in
);

  localparam int IW = $clog2(IN_W + 1);

  logic [IW-1:0] acc;

  always_comb begin
    acc      = '0;
    o_offset = '0;
    for (int l = 0; l < IN_W; l++) begin
      o_offset[l] = acc;
      acc         = acc + IW'(i_valid[l]);
    end
    o_n_in = acc;
  end

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between IF2 and ID1: compacted multi-lane enqueue,
// variable-width dequeue, branch flush and decode stall.
module inst_queue
  import Public_Info::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int IN_W  = FETCH_W,
  parameter int OUT_W = DECODE_W,
  parameter int XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [IN_W*XLEN-1:0]         i_pc,
  input  logic [IN_W*XLEN-1:0]         i_ir,
  input  logic [IN_W-1:0]              i_valid,
  input  logic                         flush_BR,
  input  logic                         stall,
  input  logic [$clog2(OUT_W+1)-1:0]   i_consume,
  output logic [OUT_W*XLEN-1:0]        o_pc,
  output logic [OUT_W*XLEN-1:0]        o_ir,
  output logic [OUT_W-1:0]             o_valid,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IN_W + 1);
  localparam int OW = $clog2(OUT_W + 1);

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] ir_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [IN_W-1:0][IW-1:0] wr_off;
  logic [IW-1:0]           n_in;
  logic [CW-1:0]           n_acc;
  logic                    push_en;
  logic [OW-1:0]           avail;
  logic [OW-1:0]           n_out;
  logic [OUT_W-1:0]        rd_valid;

  lane_compact #(
    .IN_W(IN_W)
  ) u_compact (
    .i_valid (i_valid),
    .o_offset(wr_off),
    .o_n_in  (n_in)
  );

  // Full looks only at registered occupancy so IF1 never sees a path from
  // this cycle's consume; space freed by a same-cycle pop is not reused.
  assign o_full  = ({1'b0, count_q} + (CW+1)'(IN_W)) > (CW+1)'(DEPTH);
  assign push_en = !o_full && !flush_BR;
  assign n_acc   = push_en ? CW'(n_in) : '0;
  assign o_count = count_q;

  always_comb begin
    avail = (count_q >= CW'(OUT_W)) ? OW'(OUT_W) : OW'(count_q);
    if (stall) begin
      n_out = '0;
    end else if (i_consume < avail) begin
      n_out = i_consume;
    end else begin
      n_out = avail;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_BR) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_out);
      tail_d  = tail_q + PW'(n_acc);
      count_d = count_q + n_acc - CW'(n_out);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; stale slots are never visible past count.
  always_ff @(posedge clk) begin
    if (rstn && push_en) begin
      for (int l = 0; l < IN_W; l++) begin
        if (i_valid[l]) begin
          pc_mem[tail_q + PW'(wr_off[l])] <= i_pc[l*XLEN +: XLEN];
          ir_mem[tail_q + PW'(wr_off[l])] <= i_ir[l*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    o_pc     = '0;
    o_ir     = '0;
    for (int k = 0; k < OUT_W; k++) begin
      rd_valid[k] = count_q > CW'(k);
      if (rd_valid[k]) begin
        o_pc[k*XLEN +: XLEN] = pc_mem[head_q + PW'(k)];
        o_ir[k*XLEN +: XLEN] = ir_mem[head_q + PW'(k)];
      end
    end
  end

  assign o_valid = rd_valid;

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue with an in-order queue model
// and a snapshot scoreboard drained by an independent monitor.
module tb_inst_queue;

  localparam int DEPTH = 16;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(OUT_W + 1);

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } ent_t;

  typedef struct {
    int                     cnt;
    bit                     full;
    logic [OUT_W-1:0]       vld;
    logic [OUT_W*XLEN-1:0]  pc;
    logic [OUT_W*XLEN-1:0]  ir;
  } snap_t;

  logic                    clk;
  logic                    rstn;
  logic [IN_W*XLEN-1:0]    i_pc;
  logic [IN_W*XLEN-1:0]    i_ir;
  logic [IN_W-1:0]         i_valid;
  logic                    flush_BR;
  logic                    stall;
  logic [OW-1:0]           i_consume;
  logic [OUT_W*XLEN-1:0]   o_pc;
  logic [OUT_W*XLEN-1:0]   o_ir;
  logic [OUT_W-1:0]        o_valid;
  logic                    o_full;
  logic [CW-1:0]           o_count;

  ent_t  mq[$];
  snap_t sb_q[$];
  int    tests = 0;
  int    fails = 0;

  inst_queue #(
    .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_pc     (i_pc),
    .i_ir     (i_ir),
    .i_valid  (i_valid),
    .flush_BR (flush_BR),
    .stall    (stall),
    .i_consume(i_consume),
    .o_pc     (o_pc),
    .o_ir     (o_ir),
    .o_valid  (o_valid),
    .o_full   (o_full),
    .o_count  (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [IN_W*XLEN-1:0] pk(input logic [31:0] base);
    return {base + 32'd4, base};
  endfunction

  function automatic logic [IN_W*XLEN-1:0] irs_of(input logic [IN_W*XLEN-1:0] pcs);
    return pcs ^ {IN_W{32'hA5A5_0F0F}};
  endfunction

  // Drive one cycle of stimulus and advance the reference queue accordingly.
  task automatic step(input bit rn, input logic [IN_W-1:0] v,
                      input logic [IN_W*XLEN-1:0] pcs, input logic [IN_W*XLEN-1:0] irs,
                      input bit fl, input bit st, input logic [OW-1:0] cons);
    snap_t s;
    ent_t  e;
    bit    full;
    int    nout;
    @(negedge clk);
    rstn = rn; i_valid = v; i_pc = pcs; i_ir = irs;
    flush_BR = fl; stall = st; i_consume = cons;
    if (!rn || fl) begin
      mq.delete();
    end else begin
      full = (mq.size() + IN_W) > DEPTH;
      nout = st ? 0 : int'(cons);
      if (nout > mq.size()) nout = mq.size();
      if (nout > OUT_W) nout = OUT_W;
      for (int i = 0; i < nout; i++) mq.delete(0);
      if (!full) begin
        for (int l = 0; l < IN_W; l++) begin
          if (v[l]) begin
            e.pc = pcs[l*XLEN +: XLEN];
            e.ir = irs[l*XLEN +: XLEN];
            mq.push_back(e);
          end
        end
      end
    end
    s.cnt  = mq.size();
    s.full = (mq.size() + IN_W) > DEPTH;
    s.vld  = '0;
    s.pc   = '0;
    s.ir   = '0;
    for (int k = 0; k < OUT_W; k++) begin
      if (k < mq.size()) begin
        s.vld[k] = 1'b1;
        s.pc[k*XLEN +: XLEN] = mq[k].pc;
        s.ir[k*XLEN +: XLEN] = mq[k].ir;
      end
    end
    sb_q.push_back(s);
  endtask

  task automatic push(input logic [31:0] base, input logic [IN_W-1:0] v,
                      input logic [OW-1:0] cons);
    step(1'b1, v, pk(base), irs_of(pk(base)), 1'b0, 1'b0, cons);
  endtask

  task automatic idle(input bit st, input logic [OW-1:0] cons);
    step(1'b1, '0, '0, '0, 1'b0, st, cons);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one snapshot per sampled edge, compared just after that edge.
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
        s = sb_q.pop_front();
        chk("sb_count", 64'(o_count), 64'(s.cnt));
        chk("sb_full",  64'(o_full),  64'(s.full));
        chk("sb_valid", 64'(o_valid), 64'(s.vld));
        chk("sb_pc",    64'(o_pc),    64'(s.pc));
        chk("sb_ir",    64'(o_ir),    64'(s.ir));
      end
    end
  end

  initial begin
    logic [31:0]          b;
    logic [IN_W*XLEN-1:0] rp;
    rstn = 1'b0; i_valid = '1; i_pc = '0; i_ir = '0;
    flush_BR = 1'b0; stall = 1'b0; i_consume = '0;

    // reset with valid lanes asserted
    step(1'b0, 2'b11, pk(32'h1C00_0000), irs_of(pk(32'h1C00_0000)), 1'b0, 1'b0, 2'd0);
    step(1'b0, 2'b11, pk(32'h1C00_0000), irs_of(pk(32'h1C00_0000)), 1'b0, 1'b0, 2'd0);
    settle();
    chk("reset_count", 64'(o_count), 64'd0);
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_full",  64'(o_full),  64'd0);
    chk("reset_pc",    64'(o_pc),    64'd0);

    // fill to capacity, then one dropped push
    for (int n = 0; n < 8; n++) begin
      push(32'h1C00_0000 + 32'(8 * n), 2'b11, 2'd0);
      if (n == 6) begin
        settle();
        chk("fill7_count", 64'(o_count), 64'd14);
        chk("fill7_full",  64'(o_full),  64'd0);
      end
    end
    settle();
    chk("fill8_count", 64'(o_count), 64'd16);
    chk("fill8_full",  64'(o_full),  64'd1);
    push(32'h1C00_0040, 2'b11, 2'd0);
    settle();
    chk("drop_count", 64'(o_count), 64'd16);
    chk("drop_pc",    64'(o_pc),    64'(pk(32'h1C00_0000)));

    // lane-1-only push lands in slot 0
    step(1'b1, '0, '0, '0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 2'b10, {32'h1C00_0004, 32'hDEAD_0000}, {32'h1111_2222, 32'h3333_4444},
         1'b0, 1'b0, 2'd0);
    settle();
    chk("compact_valid", 64'(o_valid),     64'd1);
    chk("compact_pc0",   64'(o_pc[31:0]),  64'h1C00_0004);
    chk("compact_count", 64'(o_count),     64'd1);

    // steady push-2/consume-2 across pointer wrap
    step(1'b1, '0, '0, '0, 1'b1, 1'b0, 2'd0);
    push(32'h1C00_0100, 2'b11, 2'd0);
    push(32'h1C00_0108, 2'b11, 2'd0);
    for (int i = 0; i < 40; i++) begin
      push(32'h1C00_0110 + 32'(8 * i), 2'b11, 2'd2);
      settle();
      chk("steady_count", 64'(o_count), 64'd4);
      chk("steady_pc0",   64'(o_pc[31:0]), 64'(32'h1C00_0108 + 32'(8 * i)));
    end

    // flush discards same-cycle push and pop
    step(1'b1, '0, '0, '0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) push(32'h1C00_0200 + 32'(8 * i), 2'b11, 2'd0);
    settle();
    chk("preflush_count", 64'(o_count), 64'd6);
    step(1'b1, 2'b11, pk(32'h1C00_0300), irs_of(pk(32'h1C00_0300)), 1'b1, 1'b0, 2'd2);
    settle();
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_valid), 64'd0);
    idle(1'b0, 2'd0);
    idle(1'b0, 2'd2);

    // stall freezes dequeue, then oversized consume is clipped
    push(32'h1C00_0400, 2'b11, 2'd0);
    push(32'h1C00_0408, 2'b01, 2'd0);
    idle(1'b1, 2'd2);
    settle();
    chk("stall_count", 64'(o_count), 64'd3);
    chk("stall_pc0",   64'(o_pc[31:0]), 64'h1C00_0400);
    idle(1'b0, 2'd2);
    settle();
    chk("clip1_count", 64'(o_count), 64'd1);
    idle(1'b0, 2'd2);
    settle();
    chk("clip0_count", 64'(o_count), 64'd0);
    chk("clip0_valid", 64'(o_valid), 64'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      b  = $urandom;
      rp = {$urandom, $urandom};
      step(($urandom_range(0, 99) != 0),
           IN_W'($urandom_range(0, 3)),
           {b ^ 32'h0000_0004, b}, rp,
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) == 0),
           OW'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d snapshots left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
